// File: rtl/mips_pkg.sv
// Shared MIPS constants: memory geometry defaults used by the loader and the
// fetch-side memory, plus the instruction-memory loader state type.
package mips_pkg;

  localparam int MEM_WIDTH_DEFAULT  = 8;
  localparam int WORD_WIDTH_DEFAULT = 32;
  localparam int MEM_DEPTH_DEFAULT  = 1024;
  localparam int ADDR_SIZE_DEFAULT  = 32;

  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_WIDTH      = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_WORD,
    WRITE,
    DONE
  } imem_ld_state_t;

endpackage

// File: rtl/imem_loader_word_byte_serializer.sv
// Picks one byte of an instruction word, MSB first, so the big-endian
// layout expected by the fetch path is defined only here.
module word_byte_serializer
  import mips_pkg::*;
#(
  parameter int MEM_WIDTH  = MEM_WIDTH_DEFAULT,
  parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT
) (
  input  logic [WORD_WIDTH-1:0] word_i,
  input  logic [IDX_WIDTH-1:0]  idx_i,
  output logic [MEM_WIDTH-1:0]  byte_o
);

  logic [WORD_WIDTH-1:0] shifted;

  // Shift the selected byte up to the top so index 0 yields the MSB.
  always_comb begin
    shifted = word_i << (MEM_WIDTH * idx_i);
    byte_o  = shifted[WORD_WIDTH-1 -: MEM_WIDTH];
  end

endmodule

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into the byte-wide instruction memory,
// big-endian, while stalling the CPU. Optional IMEM_LOADER_CHECKSUM_EN adds a running XOR.
module imem_loader
  import mips_pkg::*;
#(
  parameter int MEM_WIDTH  = MEM_WIDTH_DEFAULT,
  parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT,
  parameter int MEM_DEPTH  = MEM_DEPTH_DEFAULT,
  parameter int ADDR_SIZE  = ADDR_SIZE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_SIZE-1:0]  base_addr,
  input  logic [ADDR_SIZE-1:0]  word_count,
  input  logic                  in_valid,
  input  logic [WORD_WIDTH-1:0] in_word,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_SIZE-1:0]  mem_addr,
  output logic [MEM_WIDTH-1:0]  mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  wrap_err
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [WORD_WIDTH-1:0] checksum
`endif
);

  localparam logic [ADDR_SIZE-1:0] ADDR_MASK  = ADDR_SIZE'(MEM_DEPTH - 1);
  localparam logic [ADDR_SIZE-1:0] DEPTH_LIM  = ADDR_SIZE'(MEM_DEPTH);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX   = IDX_WIDTH'(BYTES_PER_WORD - 1);

  imem_ld_state_t        state_q, state_d;
  logic [ADDR_SIZE-1:0]  ptr_q, ptr_d;
  logic [ADDR_SIZE-1:0]  remaining_q, remaining_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic                  start_acc;

  logic                  in_ready_q, in_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_SIZE-1:0]  mem_addr_q, mem_addr_d;
  logic [MEM_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  done_q, done_d;
  logic                  wrap_err_q, wrap_err_d;
  logic [MEM_WIDTH-1:0]  byte_next;

  // Outputs are registered from next-state values, so they line up with the state they describe.
  word_byte_serializer #(
    .MEM_WIDTH  (MEM_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_serializer (
    .word_i (word_d),
    .idx_i  (idx_d),
    .byte_o (byte_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      done_q      <= 1'b0;
      wrap_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      wrap_err_q  <= wrap_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    word_d      = word_q;
    start_acc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_acc   = 1'b1;
          ptr_d       = base_addr;
          remaining_d = word_count;
          state_d     = (word_count == '0) ? DONE : WAIT_WORD;
        end
      end
      WAIT_WORD: begin
        if (in_valid) begin
          word_d  = in_word;
          idx_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        ptr_d = ptr_q + ADDR_SIZE'(1);
        idx_d = idx_q + IDX_WIDTH'(1);
        if (idx_q == LAST_IDX) begin
          remaining_d = remaining_q - ADDR_SIZE'(1);
          state_d     = (remaining_q == ADDR_SIZE'(1)) ? DONE : WAIT_WORD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The wrap flag is judged on the unreduced pointer of the byte about to be written.
  always_comb begin
    in_ready_d  = (state_d == WAIT_WORD);
    mem_we_d    = (state_d == WRITE);
    mem_addr_d  = mem_we_d ? (ptr_d & ADDR_MASK) : '0;
    mem_wdata_d = mem_we_d ? byte_next : '0;
    cpu_hold_d  = (state_d != IDLE);
    done_d      = (state_d == DONE);
    wrap_err_d  = start_acc ? 1'b0 : (wrap_err_q | (mem_we_d && (ptr_d >= DEPTH_LIM)));
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign wrap_err  = wrap_err_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (start_acc) begin
      checksum_d = '0;
    end else if (state_q == WAIT_WORD && in_valid) begin
      checksum_d = checksum_q ^ in_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Table-driven bench for imem_loader: each record is a load with hand-computed
// timing, wrap flag and read-back word; reset-mid-load and checksum are hand sequences.
module tb_imem_loader;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] count;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] gap;
    logic [31:0] spurCyc;
    logic [31:0] expDoneCyc;
    logic        expWrap;
    logic [31:0] rbAddr;
    logic [31:0] rbWord;
  } loadVec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] word_count;
  logic        in_valid;
  logic [31:0] in_word;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        wrap_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int compared;
  int mismatched;
  int doneCount;
  logic [7:0]  memModel [1024];
  logic [39:0] writeLog [$];
  loadVec_t    vecs [7];

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_word    (in_word),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .wrap_err   (wrap_err)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-wide memory model fed by the write port, plus a log of every write and done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        memModel[mem_addr[9:0]] = mem_wdata;
        writeLog.push_back({mem_addr, mem_wdata});
      end
      if (done) doneCount++;
    end
  end

  // Hard stop in case something never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] wordAt(input loadVec_t v, input int i);
    case (i)
      0:       return v.w0;
      1:       return v.w1;
      default: return v.w2;
    endcase
  endfunction

  function automatic logic [31:0] fetchWord(input logic [31:0] a);
    logic [9:0] b;
    b = a[9:0];
    return {memModel[b], memModel[b + 10'd1], memModel[b + 10'd2], memModel[b + 10'd3]};
  endfunction

  // One complete load: drives start and the word stream, checks cycle-level behaviour, then the written bytes.
  task automatic applyStimulus(input loadVec_t v);
    int wi;
    int gapLeft;
    int doneCyc;
    logic [31:0] w;
    logic [7:0]  expByte;
    @(negedge clk);
    start      = 1'b1;
    base_addr  = v.base;
    word_count = v.count;
    in_valid   = 1'b0;
    writeLog.delete();
    doneCount  = 0;
    wi         = 0;
    gapLeft    = 0;
    doneCyc    = -1;
    for (int c = 1; c <= 200 && doneCyc < 0; c++) begin
      @(negedge clk);
      start = (c == int'(v.spurCyc));
      if (start) begin
        base_addr  = 32'd500;
        word_count = 32'd5;
      end
      if (c == 1) checkOutput("startClearsWrap", 32'(wrap_err), 32'd0);
      checkOutput("cpuHoldDuringLoad", 32'(cpu_hold), 32'd1);
      checkOutput("readyWeExclusive", 32'(in_ready & mem_we), 32'd0);
      if (done) doneCyc = c;
      if (wi < int'(v.count) && gapLeft == 0) begin
        in_valid = 1'b1;
        in_word  = wordAt(v, wi);
        if (in_ready) begin
          wi++;
          gapLeft = (wi < int'(v.count)) ? int'(v.gap) : 0;
        end
      end else begin
        in_valid = 1'b0;
        if (in_ready && gapLeft > 0) begin
          checkOutput("backpressureNoWrite", 32'(mem_we), 32'd0);
          gapLeft--;
        end
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    checkOutput("doneCycle", 32'(doneCyc), v.expDoneCyc);
    checkOutput("wrapAtDone", 32'(wrap_err), 32'(v.expWrap));
    @(negedge clk);
    checkOutput("holdFallsAfterDone", 32'(cpu_hold), 32'd0);
    checkOutput("donePulseOneCycle", 32'(done), 32'd0);
    @(negedge clk);
    checkOutput("idleAfterLoad", 32'(cpu_hold | done | in_ready | mem_we), 32'd0);
    checkOutput("doneCount", 32'(doneCount), 32'd1);
    checkOutput("byteWriteCount", 32'(writeLog.size()), v.count * 32'd4);
    for (int i = 0; i < writeLog.size() && i < 12; i++) begin
      w       = wordAt(v, i / 4);
      expByte = 8'(w >> (8 * (3 - (i % 4))));
      checkOutput("byteAddr", writeLog[i][39:8], (v.base + 32'(i)) & 32'h3FF);
      checkOutput("byteData", 32'(writeLog[i][7:0]), 32'(expByte));
    end
    if (v.count != 0) checkOutput("readbackFetch", fetchWord(v.rbAddr), v.rbWord);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    doneCount  = 0;
    foreach (memModel[i]) memModel[i] = 8'h00;
    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    in_valid   = 1'b0;
    in_word    = '0;

    //          base     count  w0            w1            w2            gap    spur   done    wrap  rbAddr   rbWord
    vecs[0] = '{32'd0,    32'd1, 32'h20080005, 32'h0,        32'h0,        32'd0, 32'd0, 32'd6,  1'b0, 32'd0,   32'h20080005};
    vecs[1] = '{32'd0,    32'd3, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'd0, 32'd0, 32'd16, 1'b0, 32'd4,   32'h55667788};
    vecs[2] = '{32'd16,   32'd2, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0,        32'd7, 32'd0, 32'd18, 1'b0, 32'd20,  32'hCAFEF00D};
    vecs[3] = '{32'd1020, 32'd2, 32'h01020304, 32'hA0B0C0D0, 32'h0,        32'd0, 32'd0, 32'd11, 1'b1, 32'd0,   32'hA0B0C0D0};
    vecs[4] = '{32'd100,  32'd1, 32'h0BADF00D, 32'h0,        32'h0,        32'd0, 32'd0, 32'd6,  1'b0, 32'd100, 32'h0BADF00D};
    vecs[5] = '{32'd64,   32'd0, 32'h0,        32'h0,        32'h0,        32'd0, 32'd0, 32'd1,  1'b0, 32'd0,   32'h0};
    vecs[6] = '{32'd200,  32'd1, 32'h13579BDF, 32'h0,        32'h0,        32'd0, 32'd3, 32'd6,  1'b0, 32'd200, 32'h13579BDF};

    repeat (2) @(negedge clk);
    checkOutput("resetInReady", 32'(in_ready), 32'd0);
    checkOutput("resetMemWe", 32'(mem_we), 32'd0);
    checkOutput("resetMemAddr", mem_addr, 32'd0);
    checkOutput("resetMemWdata", 32'(mem_wdata), 32'd0);
    checkOutput("resetCpuHold", 32'(cpu_hold), 32'd0);
    checkOutput("resetDone", 32'(done), 32'd0);
    checkOutput("resetWrapErr", 32'(wrap_err), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    checkOutput("resetChecksum", checksum, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);
    checkOutput("fetchBeforeWrap", fetchWord(32'd1020), 32'h01020304);

    // Reset while the second byte of a word is on the write port.
    @(negedge clk);
    start      = 1'b1;
    base_addr  = 32'd300;
    word_count = 32'd2;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_word  = 32'hA1B2C3D4;
    checkOutput("midResetReady", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midResetSecondByteWe", 32'(mem_we), 32'd1);
    checkOutput("midResetSecondByteAddr", mem_addr, 32'd301);
    checkOutput("midResetSecondByteData", 32'(mem_wdata), 32'hB2);
    rst = 1'b1;
    #1;
    checkOutput("asyncResetOutputs", {in_ready, mem_we, cpu_hold, done, wrap_err, 27'd0}, 32'd0);
    checkOutput("asyncResetAddr", mem_addr, 32'd0);
    checkOutput("asyncResetData", 32'(mem_wdata), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checkOutput("noDoneAfterReset", 32'(done | cpu_hold | mem_we), 32'd0);
    end
    checkOutput("firstByteKept", 32'(memModel[300]), 32'hA1);
    checkOutput("secondByteNotWritten", 32'(memModel[301]), 32'h00);

`ifdef IMEM_LOADER_CHECKSUM_EN
    applyStimulus('{32'd400, 32'd2, 32'h12345678, 32'hFFFF0000, 32'h0, 32'd0, 32'd0, 32'd11, 1'b0, 32'd400, 32'h12345678});
    checkOutput("checksumAtDone", checksum, 32'hEDCB5678);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the byte-wide instruction memory before the pipeline runs. It accepts 32-bit instruction words over a valid/ready stream and writes each word big-endian as four consecutive byte writes: MSB at the lowest address, matching the fetch path's `{M[a], M[a+1], M[a+2], M[a+3]}` concatenation. It sits between the test/boot interface and the instruction memory write port. It holds the CPU stalled (`cpu_hold`) while loading.

## Interface
- `MEM_WIDTH`, 8: memory byte width.
- `WORD_WIDTH`, 32: instruction word width; must equal 4*MEM_WIDTH.
- `MEM_DEPTH`, 1024: memory depth in bytes; power of two.
- `ADDR_SIZE`, 32: address/count width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a load; sampled only in IDLE.
- `base_addr`  in  ADDR_SIZE  first byte address; captured on accepted `start`.
- `word_count`  in  ADDR_SIZE  number of words to load; captured on accepted `start`.
- `in_valid`  in  1  `in_word` valid.
- `in_word`  in  WORD_WIDTH  instruction word.
- `in_ready`  out  1  loader can take a word.
- `mem_we`  out  1  byte write strobe.
- `mem_addr`  out  ADDR_SIZE  byte address, already reduced mod MEM_DEPTH.
- `mem_wdata`  out  MEM_WIDTH  byte data.
- `cpu_hold`  out  1  pipeline stall/flush request.
- `done`  out  1  one-cycle pulse at end of load.
- `wrap_err`  out  1  sticky: a write wrapped past MEM_DEPTH-1; cleared on accepted `start`.

## Operation
- FSM states are IDLE, WAIT_WORD, WRITE, and DONE. State, pointers, byte index and outputs are all registered.
- **IDLE.** On `start`, capture `base_addr` into `wr_ptr` and `word_count` into `remaining`, and clear `wrap_err`. Go to DONE if `word_count`==0, else to WAIT_WORD.
- **WAIT_WORD.** `in_ready`=1. On `in_valid && in_ready`, latch the word, set `idx`=0 and go to WRITE.
- **WRITE.** Runs four cycles, `idx`=0..3. In each cycle:
  - `mem_we`=1
  - `mem_addr`=`wr_ptr % MEM_DEPTH`
  - `mem_wdata`=`word[WORD_WIDTH-1-8*idx -: 8]`
  - `wr_ptr` increments by 1 per byte.
  - On `idx`==3, decrement `remaining`. Go to DONE if it reaches 0, else to WAIT_WORD.
- **DONE.** `done`=1 for one cycle, then go to IDLE.
- `cpu_hold`=1 in every state except IDLE.
- `in_ready`=0 outside WAIT_WORD. `mem_we`=0 outside WRITE.
- `start` is ignored outside IDLE.
- **Wrap.** Any byte with `wr_ptr` ≥ MEM_DEPTH (pre-modulo) is still written at the wrapped address, and sets `wrap_err`.
- **Reset mid-load.** Return to IDLE immediately. Bytes already written stay in memory, and no `done` pulse is generated.

## Timing
- Reset values: state=IDLE, `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=0, `done`=0, `wrap_err`=0.
- **Start.** `start` is sampled at edge 0. From cycle 1, `cpu_hold`=1 and `in_ready`=1.
- **Per word.** A word accepted at edge k is written in cycles k+1..k+4 (`mem_we` high). Each write commits at the edge closing that cycle.
- **Next word.** `in_ready` is high again in cycle k+5. Sustained throughput is one word per 5 cycles.
- **End of load.** `done` is high in the cycle after the last byte cycle. `cpu_hold` falls in the following cycle.
- **Zero-length load.** With `word_count`=0, `done` pulses in cycle 1 and `cpu_hold` is high only in cycle 1.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: adds output `checksum` [WORD_WIDTH-1:0], the XOR of all words accepted in the current load.
  - Cleared to 0 on accepted `start` and by `rst`.
  - Updated at the acceptance edge.
  - Stable from `done` until the next `start`.
- Undefined: no `checksum` port and no XOR register; all other behaviour is identical.

## Structure
- Shared package `mips_pkg` holds:
  - the `imem_ld_state_t` enum {IDLE, WAIT_WORD, WRITE, DONE};
  - the byte-per-word constant (4);
  - the defaults for MEM_WIDTH, WORD_WIDTH, MEM_DEPTH and ADDR_SIZE, which the fetch-side memory uses too.
- One sub-module is natural: `word_byte_serializer`. It takes the latched word and `idx` and produces the MSB-first byte. It keeps the endianness in one place. Everything else stays in `imem_loader`.

## Test plan
1. **Single word.** Reset, then `start`, `base_addr`=0, `word_count`=1, `in_word`=0x20080005. Required: byte writes 0x20, 0x08, 0x00, 0x05 at addresses 0..3 over 4 consecutive cycles, `done` one cycle later, and a read-back fetch at address 0 returning 0x20080005.
2. **Back-to-back words.** `word_count`=3 with `in_valid` held high. Required: `in_ready` pulses every 5 cycles, addresses 0..11 are written contiguously, and exactly one `done`.
3. **Backpressure.** Drop `in_valid` for 7 cycles between words. Required: the FSM waits in WAIT_WORD with `mem_we`=0 and `cpu_hold`=1, and the data is correct afterwards.
4. **Wrap.** `base_addr`=1020, `word_count`=2. Required: second-word bytes land at addresses 0..3 and `wrap_err`=1; the next `start` clears `wrap_err`.
5. **Zero length, ignored start, reset mid-load.**
   - `word_count`=0: `done` in cycle 1 and no `mem_we`.
   - `start` pulsed during WRITE: ignored.
   - `rst` asserted at the second byte of a word: all outputs return to reset values asynchronously and no `done` follows.
6. **Checksum** (`IMEM_LOADER_CHECKSUM_EN` defined). Load words 0x12345678 and 0xFFFF0000. Required: `checksum`=0xEDCB5678 at `done`.
